// File: rtl/iir_biquad_mac_sequencer_pkg.sv
// iir_seq_pkg: shared types and constants for the biquad MAC sequencer.
// No ports. Provides the FSM state type, tap index type, tap count and MAC latency.
package iir_seq_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE, GAP, DRAIN, OUT} state_t;
    typedef logic [2:0] tap_idx_t;
    localparam int NUM_TAPS = 5;
    localparam int MAC_LAT  = 2;
endpackage

// File: rtl/iir_biquad_mac_sequencer_if.sv
// iir_biquad_mac_sequencer_if: bus between the biquad sequencer and the shared MAC.
// Signals: mac_en (advance), mac_a/mac_b (32-bit signed operands), mac_c (64-bit addend),
// mac_p (64-bit result, MAC_LAT enabled cycles after issue).
// Modports: master = sequencer, slave = MAC.
interface iir_biquad_mac_sequencer_if;
    logic               mac_en;
    logic signed [31:0] mac_a;
    logic signed [31:0] mac_b;
    logic signed [63:0] mac_c;
    logic signed [63:0] mac_p;
    modport master (output mac_en, mac_a, mac_b, mac_c, input mac_p);
    modport slave  (input mac_en, mac_a, mac_b, mac_c, output mac_p);
endinterface

// File: rtl/iir_biquad_mac_sequencer_round_sat.sv
// iir_round_sat: combinational round-half-up by FRAC bits and saturate to OUT_W.
// Ports: acc (in, 64 signed accumulator), y (out, OUT_W signed result), sat (out, clamp happened).
module iir_round_sat #(
    parameter int FRAC  = 30,
    parameter int OUT_W = 16
) (
    input  logic signed [63:0]      acc,
    output logic signed [OUT_W-1:0] y,
    output logic                    sat
);
    // 65-bit working width so adding the half-LSB never wraps; FRAC=0 gives HALF=0
    localparam logic signed [64:0] HALF = (65'sd1 <<< FRAC) >>> 1;
    localparam logic signed [64:0] MAX  = (65'sd1 <<< (OUT_W - 1)) - 65'sd1;
    localparam logic signed [64:0] MIN  = -(65'sd1 <<< (OUT_W - 1));
    logic signed [64:0] r;
    logic               hi;
    logic               lo;
    assign r   = (65'(acc) + HALF) >>> FRAC;
    assign hi  = r > MAX;
    assign lo  = r < MIN;
    assign sat = hi | lo;
    assign y   = hi ? MAX[OUT_W-1:0] : lo ? MIN[OUT_W-1:0] : r[OUT_W-1:0];
endmodule

// File: rtl/iir_biquad_mac_sequencer.sv
// iir_biquad_mac_sequencer: time-multiplexed Direct-Form-I biquad driving a shared registered MAC.
// Ports: clk, reset (sync, active-high), enable (global advance);
// in_valid/in_ready/in_data: sample handshake; coef_b0..coef_a2n: Q2.30 coefficients (a*n pre-negated);
// mac: MAC bus master; out_valid/out_data/out_acc: one-cycle result pulse;
// sat_flag: sticky saturation flag; sat_count: saturating count of saturated outputs.
module iir_biquad_mac_sequencer
    import iir_seq_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16,
    parameter int FRAC  = 30,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [IN_W-1:0]     in_data,
    input  logic signed [31:0]         coef_b0,
    input  logic signed [31:0]         coef_b1,
    input  logic signed [31:0]         coef_b2,
    input  logic signed [31:0]         coef_a1n,
    input  logic signed [31:0]         coef_a2n,
    iir_biquad_mac_sequencer_if.master mac,
    output logic                       out_valid,
    output logic signed [OUT_W-1:0]    out_data,
    output logic signed [63:0]         out_acc,
    output logic                       sat_flag,
    output logic [CNT_W-1:0]           sat_count
);
    state_t                  state_q, state_d;
    tap_idx_t                tap_q, tap_d;
    logic signed [IN_W-1:0]  x0_q, x0_d, x1_q, x1_d, x2_q, x2_d;
    logic signed [OUT_W-1:0] y1_q, y1_d, y2_q, y2_d;
    logic signed [31:0]      coef_q [NUM_TAPS];
    logic signed [31:0]      coef_d [NUM_TAPS];
    logic                    out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;
    logic signed [63:0]      out_acc_q, out_acc_d;
    logic                    sat_flag_q, sat_flag_d;
    logic [CNT_W-1:0]        sat_count_q, sat_count_d;
    logic signed [OUT_W-1:0] rs_y;
    logic                    rs_sat;
    logic signed [31:0]      tap_a;
    logic                    issue;
    logic                    accept;

    iir_round_sat #(.FRAC(FRAC), .OUT_W(OUT_W)) u_round_sat (
        .acc (mac.mac_p),
        .y   (rs_y),
        .sat (rs_sat)
    );

    assign in_ready  = enable & ~reset & (state_q == IDLE || state_q == OUT);
    assign accept    = in_valid & in_ready;
    assign issue     = state_q == ISSUE;
    assign tap_a     = tap_q == 3'd0 ? 32'(x0_q) : tap_q == 3'd1 ? 32'(x1_q) :
                       tap_q == 3'd2 ? 32'(x2_q) : tap_q == 3'd3 ? 32'(y1_q) : 32'(y2_q);
    assign mac.mac_en = enable & ~reset;
    assign mac.mac_a  = issue ? tap_a : '0;
    assign mac.mac_b  = issue ? coef_q[tap_q] : '0;
    // Chaining: op k adds the result of op k-1, which lands on mac_p exactly as op k issues
    assign mac.mac_c  = issue && tap_q != '0 ? mac.mac_p : '0;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_acc    = out_acc_q;
    assign sat_flag   = sat_flag_q;
    assign sat_count  = sat_count_q;

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        x0_d        = x0_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        y1_d        = y1_q;
        y2_d        = y2_q;
        coef_d      = coef_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_acc_d   = out_acc_q;
        sat_flag_d  = sat_flag_q;
        sat_count_d = sat_count_q;
        if (enable) begin
            out_valid_d = 1'b0;
            unique case (state_q)
                IDLE, OUT: state_d = IDLE;
                ISSUE:     state_d = GAP;
                GAP: begin
                    state_d = tap_q == tap_idx_t'(NUM_TAPS - 1) ? DRAIN : ISSUE;
                    tap_d   = tap_q + 1'b1;
                end
                DRAIN: begin
                    state_d     = OUT;
                    out_valid_d = 1'b1;
                    out_acc_d   = mac.mac_p;
                    out_data_d  = rs_y;
                    x1_d        = x0_q;
                    x2_d        = x1_q;
                    y1_d        = rs_y;
                    y2_d        = y1_q;
                    sat_flag_d  = sat_flag_q | rs_sat;
                    sat_count_d = rs_sat && !(&sat_count_q) ? sat_count_q + 1'b1 : sat_count_q;
                end
            endcase
            if (accept) begin
                state_d = ISSUE;
                tap_d   = '0;
                x0_d    = in_data;
                coef_d  = '{coef_b0, coef_b1, coef_b2, coef_a1n, coef_a2n};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            tap_q       <= '0;
            x0_q        <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            y1_q        <= '0;
            y2_q        <= '0;
            coef_q      <= '{default: '0};
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_acc_q   <= '0;
            sat_flag_q  <= 1'b0;
            sat_count_q <= '0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            y1_q        <= y1_d;
            y2_q        <= y2_d;
            coef_q      <= coef_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_acc_q   <= out_acc_d;
            sat_flag_q  <= sat_flag_d;
            sat_count_q <= sat_count_d;
        end
    end
endmodule

// File: tb/tb_iir_biquad_mac_sequencer.sv
// tb_iir_biquad_mac_sequencer: scoreboard bench pairing the sequencer with a behavioural MAC.
module tb_iir_biquad_mac_sequencer;
    import iir_seq_pkg::*;

    logic               clk = 0;
    logic               reset = 1;
    logic               enable = 1;
    logic               in_valid = 0;
    logic               in_ready;
    logic signed [15:0] in_data = 0;
    logic signed [31:0] b0 = 0, b1 = 0, b2 = 0, a1 = 0, a2 = 0;
    logic               out_valid;
    logic signed [15:0] out_data;
    logic signed [63:0] out_acc;
    logic               sat_flag;
    logic [15:0]        sat_count;

    int total = 0, bad = 0, cyc = 0, acc_cyc = 0;
    longint en_cnt = 0;

    typedef struct {
        longint data;
        longint acc;
        longint flag;
        longint cnt;
        longint due;
    } exp_t;
    exp_t sb[$];
    exp_t me;
    longint mx1 = 0, mx2 = 0, my1 = 0, my2 = 0, msat = 0, mflag = 0, macc, mr;

    iir_biquad_mac_sequencer_if mac_if();

    // Shared MAC: product plus addend, result visible MAC_LAT enabled cycles after issue
    logic signed [63:0] pipe [MAC_LAT] = '{default: 0};
    always @(posedge clk) if (mac_if.mac_en) begin
        pipe[0] <= mac_if.mac_a * mac_if.mac_b + mac_if.mac_c;
        for (int i = 1; i < MAC_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mac_if.mac_p = pipe[MAC_LAT-1];

    iir_biquad_mac_sequencer dut (
        .clk(clk), .reset(reset), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .coef_b0(b0), .coef_b1(b1), .coef_b2(b2), .coef_a1n(a1), .coef_a2n(a2),
        .mac(mac_if),
        .out_valid(out_valid), .out_data(out_data), .out_acc(out_acc),
        .sat_flag(sat_flag), .sat_count(sat_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    // Monitor and reference model: y[n] = b0*x0 + b1*x1 + b2*x2 + a1n*y1 + a2n*y2 in wrapping
    // 64-bit arithmetic, then round-half-up by 2^30 and clamp to int16.
    always @(negedge clk) begin
        chk("mac_en", longint'(mac_if.mac_en), longint'(enable && !reset));
        if (reset || !enable) chk("in_ready_blocked", longint'(in_ready), 0);
        if (reset) begin
            sb.delete();
            mx1 = 0; mx2 = 0; my1 = 0; my2 = 0; msat = 0; mflag = 0;
        end else if (enable) begin
            if (out_valid) begin
                if (sb.size() == 0) chk("unexpected_out_valid", longint'(out_valid), 0);
                else begin
                    me = sb.pop_front();
                    chk("out_data", longint'(out_data), me.data);
                    chk("out_acc", longint'(out_acc), me.acc);
                    chk("sat_flag", longint'(sat_flag), me.flag);
                    chk("sat_count", longint'(sat_count), me.cnt);
                    chk("out_timing", en_cnt, me.due);
                end
            end
            if (in_valid && in_ready) begin
                macc = longint'(b0) * longint'(in_data) + longint'(b1) * mx1 + longint'(b2) * mx2
                     + longint'(a1) * my1 + longint'(a2) * my2;
                mr = (macc >>> 30) + ((macc >>> 29) & 1);
                me.acc  = macc;
                me.data = mr > 32767 ? 32767 : mr < -32768 ? -32768 : mr;
                if (me.data != mr) begin
                    mflag = 1;
                    msat  = msat < 65535 ? msat + 1 : msat;
                end
                me.flag = mflag;
                me.cnt  = msat;
                me.due  = en_cnt + 12;
                mx2 = mx1; mx1 = longint'(in_data); my2 = my1; my1 = me.data;
                sb.push_back(me);
            end
            en_cnt++;
        end
    end

    task automatic set_coefs(input logic signed [31:0] c0, c1, c2, c3, c4);
        b0 = c0; b1 = c1; b2 = c2; a1 = c3; a2 = c4;
    endtask

    task automatic do_reset();
        reset = 1; in_valid = 0; enable = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic send(input logic signed [15:0] x);
        bit ok = 0;
        in_valid = 1; in_data = x;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
        end
        acc_cyc = cyc;
        chk("accepted", longint'(ok), 1);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic run(input logic signed [15:0] x, input longint want, input int lat,
                       input int fz_at, input int fz_len);
        bit seen = 0;
        send(x);
        for (int i = 0; i < 40 && !seen; i++) begin
            if (cyc - acc_cyc == fz_at) enable = 0;
            if (cyc - acc_cyc == fz_at + fz_len) enable = 1;
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                chk("run_data", longint'(out_data), want);
                chk("run_latency", longint'(cyc - acc_cyc), longint'(lat));
            end
            @(posedge clk); #1;
        end
        chk("run_out_seen", longint'(seen), 1);
    endtask

    initial begin
        int last, n, sent, guard;
        bit hs, ok;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", longint'(in_ready), 0);
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data", longint'(out_data), 0);
        chk("rst_out_acc", longint'(out_acc), 0);
        chk("rst_sat_flag", longint'(sat_flag), 0);
        chk("rst_sat_count", longint'(sat_count), 0);
        chk("rst_mac_a", longint'(mac_if.mac_a), 0);
        chk("post_rst_in_ready", longint'(in_ready), 1);
        @(posedge clk); #1;

        set_coefs(2**30, 0, 0, 0, 0);
        run(1000, 1000, 12, 0, 0);
        run(0, 0, 12, 0, 0);
        run(0, 0, 12, 0, 0);

        do_reset();
        set_coefs(2**30, 0, 0, 2**29, 0);
        run(1000, 1000, 12, 0, 0);
        run(1000, 1500, 12, 0, 0);
        run(1000, 1750, 12, 0, 0);
        run(1000, 1875, 12, 0, 0);

        do_reset();
        set_coefs(32'sh7fff_ffff, 0, 0, 0, 0);
        run(30000, 32767, 12, 0, 0);
        chk("sat_flag_first", longint'(sat_flag), 1);
        chk("sat_count_first", longint'(sat_count), 1);
        run(-30000, -32768, 12, 0, 0);
        chk("sat_count_second", longint'(sat_count), 2);

        do_reset();
        set_coefs(2**30, 0, 0, 0, 0);
        in_valid = 1; in_data = 123; last = 0;
        for (int k = 0; k < 4; k++) begin
            ok = 0;
            for (int i = 0; i < 30 && !ok; i++) begin
                @(negedge clk);
                ok = in_ready;
            end
            chk("hold_accept_seen", longint'(ok), 1);
            if (k > 0) chk("hold_accept_gap", longint'(cyc - last), 12);
            last = cyc;
            @(posedge clk); #1;
            in_data = 16'($urandom);
        end
        in_valid = 0;
        repeat (15) @(posedge clk);
        #1;

        do_reset();
        set_coefs(2**30, 0, 0, 0, 0);
        send(1000);
        repeat (5) @(posedge clk);
        #1 reset = 1;
        @(posedge clk);
        #1 reset = 0;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("no_out_after_reset", longint'(n), 0);
        @(posedge clk); #1;
        set_coefs(0, 2**30, 0, 0, 0);
        run(1000, 0, 12, 0, 0);
        run(0, 1000, 12, 0, 0);

        do_reset();
        set_coefs(2**30, 0, 0, 0, 0);
        run(777, 777, 17, 4, 5);

        do_reset();
        sent = 0; guard = 0; hs = 0;
        while (sent < 30 && guard < 3000) begin
            @(posedge clk); #1;
            guard++;
            if (hs) begin
                sent++;
                in_valid = 0;
                set_coefs(32'($urandom), 32'($urandom_range(0, 32'h7fff_ffff) >> 1) - 32'h2000_0000,
                          32'($urandom_range(0, 32'h7fff_ffff) >> 1) - 32'h2000_0000,
                          32'($urandom_range(0, 32'h3fff_ffff) >> 1) - 32'h1000_0000, 32'($urandom));
            end
            enable = $urandom_range(0, 7) != 0;
            if (!in_valid && $urandom_range(0, 3) == 0) begin
                in_valid = 1;
                in_data  = 16'($urandom);
                set_coefs(32'($urandom_range(0, 32'h7fff_ffff) >> 1) - 32'h2000_0000,
                          32'($urandom_range(0, 32'h7fff_ffff) >> 1) - 32'h2000_0000,
                          32'($urandom_range(0, 32'h7fff_ffff) >> 1) - 32'h2000_0000,
                          32'($urandom_range(0, 32'h3fff_ffff) >> 1) - 32'h1000_0000,
                          32'($urandom_range(0, 32'h3fff_ffff) >> 1) - 32'h1000_0000);
            end
            @(negedge clk);
            hs = in_valid && in_ready;
        end
        chk("random_samples_sent", longint'(sent), 30);
        in_valid = 0; enable = 1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", longint'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $fatal(1, "FAIL watchdog: simulation did not finish, got timeout want finish");
    end
endmodule
